// File: rtl/port_ring_insert_arb_if.sv
// port_ring_insert_arb_if: ring-in, local-port and ring-out handshakes plus grant/defer status
interface port_ring_insert_arb_if #(
    parameter int w     = 66,
    parameter int cnt_w = 3
);
    logic             ri_srdy;
    logic             ri_drdy;
    logic [w-1:0]     ri_data;
    logic             lp_srdy;
    logic             lp_drdy;
    logic [w-1:0]     lp_data;
    logic             ro_srdy;
    logic             ro_drdy;
    logic [w-1:0]     ro_data;
    logic             gnt_ring;
    logic             gnt_local;
    logic [cnt_w-1:0] defer_cnt;
    modport master (
        output ri_srdy, ri_data, lp_srdy, lp_data, ro_drdy,
        input  ri_drdy, lp_drdy, ro_srdy, ro_data, gnt_ring, gnt_local, defer_cnt
    );
    modport slave (
        input  ri_srdy, ri_data, lp_srdy, lp_data, ro_drdy,
        output ri_drdy, lp_drdy, ro_srdy, ro_data, gnt_ring, gnt_local, defer_cnt
    );
endinterface

// File: rtl/port_ring_insert_arb.sv
// port_ring_insert_arb: packet-granular ring/local arbiter for one ring stop with bounded local starvation
module port_ring_insert_arb #(
    parameter int         rdp_sz     = 64,
    parameter int         pcc_lsb    = 64,
    parameter logic [1:0] pcc_eop    = 2'd2,
    parameter logic [1:0] pcc_badeop = 2'd3,
    parameter int         max_defer  = 4,
    parameter int         cnt_w      = 3
) (
    input logic                   clk,
    input logic                   reset,
    port_ring_insert_arb_if.slave bus
);
    // PCC sitting at or above rdp_sz rides alongside the payload, widening the word
    localparam int ww = (rdp_sz > pcc_lsb + 1) ? rdp_sz : pcc_lsb + 2;
    typedef enum logic [2:0] {IDLE = 3'b001, RING = 3'b010, LOCAL = 3'b100} state_t;
    state_t           state_q, state_d;
    logic [cnt_w-1:0] defer_cnt_q, defer_cnt_d;
    logic             idle, force_local, pick_local, sel_local, sel_ring, src_srdy, xfer, eop;
    logic [ww-1:0]    sel_word;
    always_comb begin
        idle        = state_q == IDLE;
        force_local = bus.lp_srdy && (defer_cnt_q >= cnt_w'(max_defer));
        pick_local  = force_local || (bus.lp_srdy && !bus.ri_srdy);
        sel_local   = idle ? pick_local : state_q == LOCAL;
        sel_ring    = idle ? (!pick_local && bus.ri_srdy) : state_q == RING;
        src_srdy    = !reset && (sel_local ? bus.lp_srdy : (sel_ring && bus.ri_srdy));
        xfer        = src_srdy && bus.ro_drdy;
        sel_word    = sel_local ? bus.lp_data : sel_ring ? bus.ri_data : '0;
        eop         = sel_word[pcc_lsb+:2] == pcc_eop || sel_word[pcc_lsb+:2] == pcc_badeop;
        state_d     = xfer ? (eop ? IDLE : sel_local ? LOCAL : RING) : state_q;
        // starvation count moves only when a packet starts
        defer_cnt_d = !(idle && xfer) ? defer_cnt_q :
                      sel_local ? '0 :
                      (bus.lp_srdy && defer_cnt_q != '1) ? defer_cnt_q + cnt_w'(1) : defer_cnt_q;
    end
    assign bus.ro_srdy   = src_srdy;
    assign bus.ri_drdy   = xfer && sel_ring;
    assign bus.lp_drdy   = xfer && sel_local;
    assign bus.ro_data   = sel_word;
    assign bus.gnt_ring  = state_q == RING;
    assign bus.gnt_local = state_q == LOCAL;
    assign bus.defer_cnt = defer_cnt_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            defer_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            defer_cnt_q <= defer_cnt_d;
        end
    end
endmodule

// File: tb/tb_port_ring_insert_arb.sv
// tb_port_ring_insert_arb: scoreboard bench for the ring/local insertion arbiter
module tb_port_ring_insert_arb;
    typedef struct {
        logic        src;
        logic        first;
        logic [2:0]  dfr;
        logic [65:0] w;
    } ent_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [65:0] ring_q[$];
    logic [65:0] lp_q[$];
    ent_t        exp_q[$];
    logic        tr, tl, pend;
    logic [2:0]  pend_d;
    port_ring_insert_arb_if #(.w(66), .cnt_w(3)) bus ();
    port_ring_insert_arb dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask
    function automatic logic [65:0] mkw(input logic src, input int id, input int i, input int n, input logic bad);
        logic [1:0] pcc;
        pcc = (i == n - 1) ? (bad ? 2'd3 : 2'd2) : 2'd0;
        return {pcc, 32'(id) ^ 32'hA5A5_0000, src, 15'(i), 16'hBEEF};
    endfunction
    task automatic send(input logic src, input int id, input int n, input logic bad);
        for (int i = 0; i < n; i++)
            if (src) lp_q.push_back(mkw(src, id, i, n, bad));
            else ring_q.push_back(mkw(src, id, i, n, bad));
    endtask
    task automatic exp_pkt(input logic src, input int id, input int n, input logic bad, input logic [2:0] dfr);
        ent_t e;
        for (int i = 0; i < n; i++) begin
            e.src = src; e.first = (i == 0); e.dfr = dfr; e.w = mkw(src, id, i, n, bad);
            exp_q.push_back(e);
        end
    endtask
    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check({tag, "_drain"}, 66'(exp_q.size()), 66'(0));
        @(posedge clk);
        #1;
    endtask
    // source model: pop a word after the cycle it was accepted, then present the next
    initial begin
        bus.ri_srdy = 1'b0; bus.ri_data = '0;
        bus.lp_srdy = 1'b0; bus.lp_data = '0;
        forever begin
            @(negedge clk);
            tr = bus.ri_drdy;
            tl = bus.lp_drdy;
            @(posedge clk);
            #2;
            if (tr && ring_q.size() > 0) void'(ring_q.pop_front());
            if (tl && lp_q.size() > 0) void'(lp_q.pop_front());
            bus.ri_srdy = ring_q.size() > 0;
            bus.ri_data = ring_q.size() > 0 ? ring_q[0] : '0;
            bus.lp_srdy = lp_q.size() > 0;
            bus.lp_data = lp_q.size() > 0 ? lp_q[0] : '0;
        end
    end
    initial begin
        ent_t e;
        pend = 1'b0;
        pend_d = '0;
        forever begin
            @(negedge clk);
            if (pend) begin
                check("defer_after_start", 66'(bus.defer_cnt), 66'(pend_d));
                pend = 1'b0;
            end
            check("drdy_without_xfer", 66'((bus.ri_drdy | bus.lp_drdy) & ~(bus.ro_srdy & bus.ro_drdy)), 66'(0));
            check("ri_drdy_in_local", 66'(bus.ri_drdy & bus.gnt_local), 66'(0));
            if (bus.ro_srdy && bus.ro_drdy) begin
                if (exp_q.size() == 0) check("unexpected_word", 66'(exp_q.size()), 66'(1));
                else begin
                    e = exp_q.pop_front();
                    check("ro_data", bus.ro_data, e.w);
                    check("ri_drdy", 66'(bus.ri_drdy), 66'(!e.src));
                    check("lp_drdy", 66'(bus.lp_drdy), 66'(e.src));
                    check("gnt_ring", 66'(bus.gnt_ring), 66'(!e.src && !e.first));
                    check("gnt_local", 66'(bus.gnt_local), 66'(e.src && !e.first));
                    if (e.first) begin
                        pend = 1'b1;
                        pend_d = e.dfr;
                    end
                end
            end
        end
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
    initial begin
        ent_t e;
        bus.ro_drdy = 1'b1;
        @(posedge clk);
        #1;
        send(1, 0, 1, 0);
        exp_pkt(1, 0, 1, 0, 3'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ro_srdy", 66'(bus.ro_srdy), 66'(0));
        check("rst_lp_drdy", 66'(bus.lp_drdy), 66'(0));
        check("rst_gnt_ring", 66'(bus.gnt_ring), 66'(0));
        check("rst_gnt_local", 66'(bus.gnt_local), 66'(0));
        check("rst_defer", 66'(bus.defer_cnt), 66'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_drain("rst_release");
        // ring-only 3-word packet in three consecutive cycles
        send(0, 1, 3, 0);
        exp_pkt(0, 1, 3, 0, 3'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t1_three_cycles", 66'(exp_q.size()), 66'(0));
        check("t1_idle", 66'(bus.gnt_ring | bus.gnt_local), 66'(0));
        @(posedge clk);
        #1;
        // contention: four ring packets, then the starved local one
        for (int i = 0; i < 5; i++) send(0, 10 + i, 2, 0);
        send(1, 20, 2, 0);
        send(1, 21, 2, 0);
        for (int i = 0; i < 4; i++) exp_pkt(0, 10 + i, 2, 0, 3'(i + 1));
        exp_pkt(1, 20, 2, 0, 3'd0);
        exp_pkt(0, 14, 2, 0, 3'd1);
        exp_pkt(1, 21, 2, 0, 3'd0);
        wait_drain("t2");
        // ring arrives mid local packet and must wait for local EOP
        send(1, 30, 4, 0);
        exp_pkt(1, 30, 4, 0, 3'd0);
        exp_pkt(0, 31, 2, 0, 3'd0);
        @(posedge clk);
        #1;
        send(0, 31, 2, 0);
        wait_drain("t3");
        // backpressure in IDLE: nothing starts, count frozen
        bus.ro_drdy = 1'b0;
        send(0, 40, 1, 0);
        send(1, 41, 1, 0);
        exp_pkt(0, 40, 1, 0, 3'd1);
        exp_pkt(1, 41, 1, 0, 3'd0);
        repeat (5) begin
            @(negedge clk);
            check("t4_ro_srdy", 66'(bus.ro_srdy), 66'(1));
            check("t4_drdy", 66'(bus.ri_drdy | bus.lp_drdy), 66'(0));
            check("t4_gnt", 66'(bus.gnt_ring | bus.gnt_local), 66'(0));
            check("t4_defer", 66'(bus.defer_cnt), 66'(0));
        end
        @(posedge clk);
        #1;
        bus.ro_drdy = 1'b1;
        wait_drain("t4");
        // single-word badeop local packet clears a nonzero count
        send(0, 50, 1, 0);
        send(0, 51, 1, 0);
        send(1, 52, 1, 1);
        exp_pkt(0, 50, 1, 0, 3'd1);
        exp_pkt(0, 51, 1, 0, 3'd2);
        exp_pkt(1, 52, 1, 1, 3'd0);
        wait_drain("t5");
        @(negedge clk);
        check("t5_gnt_local", 66'(bus.gnt_local), 66'(0));
        check("t5_defer", 66'(bus.defer_cnt), 66'(0));
        @(posedge clk);
        #1;
        // reset while word 2 of a 4-word ring packet is presented
        send(0, 60, 4, 0);
        send(1, 61, 1, 0);
        e.src = 1'b0; e.first = 1'b1; e.dfr = 3'd1; e.w = mkw(0, 60, 0, 4, 0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_ro_srdy", 66'(bus.ro_srdy), 66'(0));
        check("t6_rst_ri_drdy", 66'(bus.ri_drdy), 66'(0));
        check("t6_rst_lp_drdy", 66'(bus.lp_drdy), 66'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        ring_q.delete();
        lp_q.delete();
        @(negedge clk);
        check("t6_gnt_ring", 66'(bus.gnt_ring), 66'(0));
        check("t6_gnt_local", 66'(bus.gnt_local), 66'(0));
        check("t6_defer", 66'(bus.defer_cnt), 66'(0));
        check("t6_ro_srdy", 66'(bus.ro_srdy), 66'(0));
        check("t6_drdy", 66'(bus.ri_drdy | bus.lp_drdy), 66'(0));
        check("t6_exp_empty", 66'(exp_q.size()), 66'(0));
        @(posedge clk);
        #1;
        // traffic resumes cleanly after the mid-packet reset
        send(0, 70, 2, 0);
        exp_pkt(0, 70, 2, 0, 3'd0);
        wait_drain("t7");
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
